// File: rtl/data_sram_like_slave.sv
// data_sram_like_slave
//   Responder end of the SRAM-like data interface. Accepts req/addr_ok
//   handshakes, applies byte-masked writes to an internal word memory,
//   snapshots read data at accept time and returns data_ok/rdata strictly
//   in request order, with up to FIFO_DEPTH requests outstanding.
//
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   req           request valid, held until addr_ok
//   wr            1=write, 0=read
//   size          access size (informational; lanes come from wstrb)
//   wstrb         byte-lane write enables
//   addr          byte address (word index = addr[MEM_AW+1:2])
//   wdata         lane-replicated write data
//   addr_ok       request accepted this cycle
//   data_ok       response for oldest outstanding request
//   rdata         read data, valid with data_ok (0 for writes)
//   addr_stall    forces addr_ok=0
//   data_stall    forces data_ok=0
module data_sram_like_slave #(
  parameter int MEM_AW     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RESP_LAT   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        addr_stall,
  input  logic        data_stall
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int AGW = $clog2(RESP_LAT + 1);
  localparam logic [AGW-1:0] LAT   = AGW'(RESP_LAT);
  localparam logic [CW-1:0]  DEPTH = CW'(FIFO_DEPTH);

  logic [31:0]     mem    [2**MEM_AW];
  logic            wr_q   [FIFO_DEPTH];
  logic [31:0]     snap_q [FIFO_DEPTH];
  logic [AGW-1:0]  age_q  [FIFO_DEPTH];

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [MEM_AW-1:0] idx;
  logic              full, head_valid, push, pop;
  logic              unused_bits;

  assign idx         = addr[MEM_AW+1:2];
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  always_comb begin
    full       = (count == DEPTH);
    head_valid = (count != '0);
    addr_ok    = req & ~full & ~addr_stall;
    push       = req & addr_ok;
    data_ok    = head_valid & (age_q[rd_ptr] >= LAT) & ~data_stall;
    pop        = data_ok;
    rdata      = (data_ok & ~wr_q[rd_ptr]) ? snap_q[rd_ptr] : '0;
  end

  // Memory contents survive reset; only accepts outside reset modify it.
  always_ff @(posedge clk) begin
    if (resetn && push && wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // An entry is stored with age 1: that is its age in the cycle after the
  // accept edge, so age==k holds k cycles after accept and data_ok can
  // appear no earlier than RESP_LAT cycles after accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (age_q[i] < LAT) age_q[i] <= age_q[i] + AGW'(1);
      end
      if (push) begin
        wr_q[wr_ptr]   <= wr;
        snap_q[wr_ptr] <= wr ? '0 : mem[idx];
        age_q[wr_ptr]  <= AGW'(1);
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_like_slave.sv
module tb_data_sram_like_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        addr_stall, data_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_sram_like_slave #(.MEM_AW(12), .FIFO_DEPTH(4), .RESP_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .addr_stall(addr_stall),
    .data_stall(data_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; wstrb = s; addr = a; wdata = d; size = 2'd2;
  endtask

  // Write accepted in cycle B, read in B+1; write response in B+2,
  // read response in B+3 (RESP_LAT=2 after its accept), idle in B+4.
  task automatic wr_then_rd(input string t, input logic [31:0] wa, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [31:0] ra,
                            input logic [31:0] exp);
    @(negedge clk); drv(1'b1, 1'b1, ws, wa, wd); #1;
    chk({t, "_wr_acc"}, 32'(addr_ok), 32'd1);
    chk({t, "_idle0"}, 32'(data_ok), 32'd0);
    @(negedge clk); drv(1'b1, 1'b0, 4'h0, ra, 32'h0); #1;
    chk({t, "_rd_acc"}, 32'(addr_ok), 32'd1);
    chk({t, "_wr_early"}, 32'(data_ok), 32'd0);
    @(negedge clk); drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk({t, "_wr_ok"}, 32'(data_ok), 32'd1);
    chk({t, "_wr_rdata"}, rdata, 32'h0);
    @(negedge clk); #1;
    chk({t, "_rd_ok"}, 32'(data_ok), 32'd1);
    chk({t, "_rd_rdata"}, rdata, exp);
    @(negedge clk); #1;
    chk({t, "_drained"}, 32'(data_ok), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra  [5];
    logic [31:0] rex [5];
    ra  = '{32'h1000, 32'h2000, 32'h1000, 32'h2000, 32'h1000};
    rex = '{32'h11AA3344, 32'h5, 32'h11AA3344, 32'h5, 32'h11AA3344};

    resetn = 1'b0; addr_stall = 1'b0; data_stall = 1'b0;
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr_ok", 32'(addr_ok), 32'd0);
    chk("rst_data_ok", 32'(data_ok), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); resetn = 1'b1; #1;
    chk("post_rst_data_ok", 32'(data_ok), 32'd0);

    // Full-word write then read back; byte-lane merge; word at 0x2000.
    wr_then_rd("t1", 32'h1000, 32'h11223344, 4'hf, 32'h1000, 32'h11223344);
    wr_then_rd("t2", 32'h1002, 32'hAAAAAAAA, 4'b0100, 32'h1000, 32'h11AA3344);
    wr_then_rd("t3", 32'h2000, 32'h00000005, 4'hf, 32'h2000, 32'h00000005);

    // Back-pressure on the response side fills the FIFO.
    data_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drv(1'b1, 1'b0, 4'h0, ra[k], 32'h0); #1;
      chk($sformatf("t4_acc%0d", k), 32'(addr_ok), 32'd1);
    end
    @(negedge clk); drv(1'b1, 1'b0, 4'h0, ra[4], 32'h0); #1;
    chk("t4_full", 32'(addr_ok), 32'd0);
    chk("t4_stalled", 32'(data_ok), 32'd0);
    @(negedge clk); #1;
    chk("t4_full2", 32'(addr_ok), 32'd0);
    @(negedge clk); data_stall = 1'b0; #1;
    chk("t4_ok0", 32'(data_ok), 32'd1);
    chk("t4_rd0", rdata, rex[0]);
    chk("t4_pop_no_free", 32'(addr_ok), 32'd0);
    @(negedge clk); #1;
    chk("t4_acc4", 32'(addr_ok), 32'd1);
    chk("t4_ok1", 32'(data_ok), 32'd1);
    chk("t4_rd1", rdata, rex[1]);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk); drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
      chk($sformatf("t4_ok%0d", k), 32'(data_ok), 32'd1);
      chk($sformatf("t4_rd%0d", k), rdata, rex[k]);
    end
    @(negedge clk); #1;
    chk("t4_drained", 32'(data_ok), 32'd0);

    // Back-pressure on the request side.
    addr_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drv(1'b1, 1'b0, 4'h0, 32'h2000, 32'h0); #1;
      chk($sformatf("t5_stall%0d", k), 32'(addr_ok), 32'd0);
      chk($sformatf("t5_none%0d", k), 32'(data_ok), 32'd0);
    end
    @(negedge clk); addr_stall = 1'b0; #1;
    chk("t5_acc", 32'(addr_ok), 32'd1);
    @(negedge clk); drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("t5_early", 32'(data_ok), 32'd0);
    @(negedge clk); #1;
    chk("t5_ok", 32'(data_ok), 32'd1);
    chk("t5_rd", rdata, 32'h5);
    @(negedge clk); #1;
    chk("t5_drained", 32'(data_ok), 32'd0);

    // Reset with pending reads discards them but keeps memory.
    data_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drv(1'b1, 1'b0, 4'h0, ra[k], 32'h0); #1;
      chk($sformatf("t6_acc%0d", k), 32'(addr_ok), 32'd1);
    end
    @(negedge clk); drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1; data_stall = 1'b0; #1;
    chk("t6_flush0", 32'(data_ok), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t6_flush%0d", k), 32'(data_ok), 32'd0);
    end
    // 0x5003 aliases word index 0x400 (same as 0x1000).
    @(negedge clk); drv(1'b1, 1'b0, 4'h0, 32'h5003, 32'h0); #1;
    chk("t6_acc_after", 32'(addr_ok), 32'd1);
    @(negedge clk); drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("t6_early", 32'(data_ok), 32'd0);
    @(negedge clk); #1;
    chk("t6_ok", 32'(data_ok), 32'd1);
    chk("t6_alias_rd", rdata, 32'h11AA3344);
    @(negedge clk); #1;
    chk("t6_drained", 32'(data_ok), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
